// File: rtl/ram_fifo_pkg.sv
// -----------------------------------------------------------------------------
// ram_fifo_pkg
//   Shared types and sizing for the RAM-backed FIFO controller (ram_fifo_ctrl).
//   The FIFO sits in front of a 32x3 single-port synchronous RAM. Because the
//   pointers wrap naturally, DEPTH must equal 2**ADDR_W.
//
//   Contents:
//     ADDR_W, DATA_W, DEPTH : sizing localparams
//     fifo_state_t          : controller FSM encoding
//     addr_t, word_t        : RAM address / data word types
//     count_t               : occupancy type (one bit wider than addr_t)
// -----------------------------------------------------------------------------
package ram_fifo_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 3;
    localparam int DEPTH  = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_CAP  = 2'd2
    } fifo_state_t;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W:0]   count_t;

    localparam count_t COUNT_FULL = count_t'(DEPTH);

endpackage : ram_fifo_pkg

// File: rtl/ram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// ram_fifo_ctrl
//   FIFO controller that owns the address/data/write-enable inputs of an
//   external 32x3 single-port synchronous RAM and consumes its q output.
//   Push and pop requests are turned into RAM write and read cycles; the block
//   keeps the read/write pointers, occupancy count and full/empty flags.
//
//   Optional feature (compile-time macro FIFO_ERR_FLAGS_EN):
//     defined   : overflow/underflow are sticky flags set by a push while full
//                 or a pop while empty (in IDLE); cleared only by reset.
//     undefined : overflow/underflow ports exist but are tied to 0.
//
//   Ports:
//     clock        in   system clock, rising edge
//     reset        in   synchronous, active-high reset
//     push         in   write request, held until push_ack
//     wr_data      in   word to enqueue, sampled when push_ack=1
//     push_ack     out  push accepted this cycle (combinational)
//     pop          in   read request (pulse or level)
//     pop_ack      out  pop accepted this cycle (combinational)
//     rd_data      out  dequeued word (registered)
//     rd_valid     out  one-cycle pulse, rd_data valid
//     full         out  count == DEPTH
//     empty        out  count == 0
//     count        out  occupancy 0..DEPTH
//     busy         out  FSM not in IDLE
//     overflow     out  sticky push-while-full flag
//     underflow    out  sticky pop-while-empty flag
//     ram_address  out  RAM address
//     ram_data     out  RAM write data
//     ram_wren     out  RAM write enable
//     ram_q        in   RAM read data, registered at the addressing edge
//
//   FSM states:
//     state   | meaning
//     --------+------------------------------------------------------------
//     IDLE    | accepting push/pop; pop wins when both are possible
//     RD_WAIT | RAM is returning the popped word on ram_q
//     RD_CAP  | rd_data holds the popped word, rd_valid high for this cycle
// -----------------------------------------------------------------------------
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
(
    input  logic              clock,
    input  logic              reset,

    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    output logic              push_ack,

    input  logic              pop,
    output logic              pop_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,

    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              overflow,
    output logic              underflow,

    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    fifo_state_t state_q, state_d;

    addr_t  wr_ptr_q, wr_ptr_d;
    addr_t  rd_ptr_q, rd_ptr_d;
    count_t count_q,  count_d;
    word_t  rd_data_q, rd_data_d;
    logic   rd_valid_q, rd_valid_d;

    logic   push_acc;
    logic   pop_acc;
    logic   full_w;
    logic   empty_w;

    assign full_w  = (count_q == COUNT_FULL);
    assign empty_w = (count_q == '0);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pop_acc) state_d = RD_WAIT;
            RD_WAIT: state_d = RD_CAP;
            RD_CAP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic: arbitration and RAM port drive
    // -------------------------------------------------------------------------
    always_comb begin
        pop_acc     = 1'b0;
        push_acc    = 1'b0;
        ram_wren    = 1'b0;
        ram_address = rd_ptr_q;
        ram_data    = '0;
        unique case (state_q)
            IDLE: begin
                pop_acc  = pop & ~empty_w;
                push_acc = push & ~full_w & ~pop_acc;
                if (push_acc) begin
                    ram_wren    = 1'b1;
                    ram_address = wr_ptr_q;
                    ram_data    = wr_data;
                end
            end
            // rd_ptr has already advanced; keep the popped entry's address
            // on the RAM so its q stays stable through capture.
            RD_WAIT: ram_address = rd_ptr_q - addr_t'(1);
            RD_CAP:  ram_address = rd_ptr_q;
            default: ram_address = rd_ptr_q;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath next-state
    // -------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;

        // push_acc and pop_acc are mutually exclusive, so count never sees
        // both an increment and a decrement in one cycle.
        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + addr_t'(1);
            count_d  = count_q + count_t'(1);
        end else if (pop_acc) begin
            rd_ptr_d = rd_ptr_q + addr_t'(1);
            count_d  = count_q - count_t'(1);
        end

        if (state_q == RD_WAIT) begin
            rd_data_d  = ram_q;
            rd_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // -------------------------------------------------------------------------
    // Sticky error flags
    // -------------------------------------------------------------------------
`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q,  overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q  | ((state_q == IDLE) & push & full_w);
        underflow_d = underflow_q | ((state_q == IDLE) & pop & empty_w);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign push_ack = push_acc;
    assign pop_ack  = pop_acc;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign full     = full_w;
    assign empty    = empty_w;
    assign count    = count_q;
    assign busy     = (state_q != IDLE);

endmodule : ram_fifo_ctrl
